mul_pipe_ex: RTL and testbench

- Multi-cycle multiply execution pipe, directly downstream of the ID/EX pipeline register.
- Accepts instructions whose mul control bit is set, along with both source operands, destination index and the write_reg flag.
- Carries them through STAGES registered stages and presents a result plus destination to writeback.
- Exposes in-flight destination information so the decode stage can detect RAW hazards.

---
 rtl/mul_pipe_pkg.sv | 22 ++
 rtl/mul_stage_reg.sv | 44 ++++
 rtl/mul_pipe_ex.sv | 100 ++++++++++
 tb/tb_mul_pipe_ex.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/mul_pipe_pkg.sv
// rtl/mul_pipe_pkg.sv - shared types and constants for the multiply execution pipe
// Carries the per-stage control record and the RAW hazard match helper.
package mul_pipe_pkg;

   localparam int MUL_STAGES_DEFAULT  = 5;
   localparam int REG_IDX_W           = 5;
   localparam int MUL_DATA_W_DEFAULT  = 32;

   // Control half of a stage; data travels alongside with a width set by the instance.
   typedef struct packed {
      logic                 valid;
      logic                 we;
      logic [REG_IDX_W-1:0] rgd_index;
   } mul_ctl_t;

   function automatic logic idx_hit(input mul_ctl_t       c,
                                    input logic [REG_IDX_W-1:0] s1,
                                    input logic [REG_IDX_W-1:0] s2);
      return c.valid & c.we & ((c.rgd_index == s1) | (c.rgd_index == s2));
   endfunction

endpackage

// File: rtl/mul_stage_reg.sv
// rtl/mul_stage_reg.sv - one multiply pipe stage register with hold enable
// Captures a zeroed record whenever the incoming slot is a bubble.
module mul_stage_reg
   import mul_pipe_pkg::*;
#(
   parameter int W = MUL_DATA_W_DEFAULT
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         en,
   input  mul_ctl_t     ctl_in,
   input  logic [W-1:0] data_in,
   output mul_ctl_t     ctl_q,
   output logic [W-1:0] data_q
);

   mul_ctl_t     ctl_d;
   logic [W-1:0] data_d;

   always_comb begin
      ctl_d  = ctl_q;
      data_d = data_q;
      if (en) begin
         if (ctl_in.valid) begin
            ctl_d  = ctl_in;
            data_d = data_in;
         end else begin
            ctl_d  = '0;
            data_d = '0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ctl_q  <= '0;
         data_q <= '0;
      end else begin
         ctl_q  <= ctl_d;
         data_q <= data_d;
      end
   end

endmodule

// File: rtl/mul_pipe_ex.sv
// rtl/mul_pipe_ex.sv - STAGES-deep multiply execution pipe with writeback and hazard outputs
// Optional decode RAW hazard detection is built when MUL_HAZARD_EN is defined.
module mul_pipe_ex
   import mul_pipe_pkg::*;
#(
   parameter int STAGES = MUL_STAGES_DEFAULT,
   parameter int DATA_W = MUL_DATA_W_DEFAULT
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 valid_in,
   input  logic                 write_reg_in,
   input  logic [REG_IDX_W-1:0] rgD_index_in,
   input  logic [DATA_W-1:0]    op_a_in,
   input  logic [DATA_W-1:0]    op_b_in,
   input  logic                 flush_in,
   input  logic                 stall_in,
   output logic                 ready_out,
   output logic                 wb_valid_out,
   output logic                 wb_we_out,
   output logic [REG_IDX_W-1:0] wb_rgD_index_out,
   output logic [DATA_W-1:0]    wb_data_out,
   output logic [STAGES-1:0]    stage_valid_out,
   input  logic [REG_IDX_W-1:0] id_rgS1_index_in,
   input  logic [REG_IDX_W-1:0] id_rgS2_index_in,
   output logic                 hazard_out
);

   mul_ctl_t            ctl_q [STAGES];
   logic [DATA_W-1:0]   stage_data [STAGES];
   logic [2*DATA_W-1:0] s0_data_q;
   logic                freeze;
   logic                advance;

   // Only a live instruction blocked at writeback stops the pipe; bubbles never stall it.
   assign freeze    = stall_in & ctl_q[STAGES-1].valid;
   assign advance   = ~freeze;
   assign ready_out = ~freeze;

   // stage_data[0] is the product formed from the stage 0 operands, captured by stage 1.
   assign stage_data[0] = s0_data_q[DATA_W-1:0] * s0_data_q[2*DATA_W-1:DATA_W];

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      if (k == 0) begin : g_first
         mul_ctl_t ctl_in;
         assign ctl_in.valid     = valid_in & ~flush_in;
         assign ctl_in.we        = write_reg_in;
         assign ctl_in.rgd_index = rgD_index_in;

         mul_stage_reg #(.W(2*DATA_W)) u_reg (
            .clk     (clk),
            .rst_n   (reset),
            .en      (advance),
            .ctl_in  (ctl_in),
            .data_in ({op_b_in, op_a_in}),
            .ctl_q   (ctl_q[0]),
            .data_q  (s0_data_q)
         );
      end else begin : g_rest
         mul_stage_reg #(.W(DATA_W)) u_reg (
            .clk     (clk),
            .rst_n   (reset),
            .en      (advance),
            .ctl_in  (ctl_q[k-1]),
            .data_in (stage_data[k-1]),
            .ctl_q   (ctl_q[k]),
            .data_q  (stage_data[k])
         );
      end
      assign stage_valid_out[k] = ctl_q[k].valid;
   end

   assign wb_valid_out     = ctl_q[STAGES-1].valid;
   assign wb_we_out        = ctl_q[STAGES-1].valid & ctl_q[STAGES-1].we;
   assign wb_rgD_index_out = ctl_q[STAGES-1].rgd_index;
   assign wb_data_out      = stage_data[STAGES-1];

`ifdef MUL_HAZARD_EN
   always_comb begin
      hazard_out = 1'b0;
      for (int k = 0; k < STAGES; k++) begin
         if (idx_hit(ctl_q[k], id_rgS1_index_in, id_rgS2_index_in)) begin
            hazard_out = 1'b1;
         end
      end
   end
`else
   logic unused_hazard;

   always_comb begin
      unused_hazard = ^{id_rgS1_index_in, id_rgS2_index_in};
      for (int k = 0; k < STAGES; k++) begin
         unused_hazard = unused_hazard ^ (^ctl_q[k]);
      end
   end

   assign hazard_out = 1'b0;
`endif

endmodule

// File: tb/tb_mul_pipe_ex.sv
// tb/tb_mul_pipe_ex.sv - directed, table-driven self-checking bench for mul_pipe_ex
module tb_mul_pipe_ex;

   localparam int S = 5;
   localparam int W = 32;

   logic          clk = 1'b0;
   logic          reset;
   logic          valid_in, write_reg_in, flush_in, stall_in;
   logic [4:0]    rgD_index_in, id_rgS1_index_in, id_rgS2_index_in;
   logic [W-1:0]  op_a_in, op_b_in;
   logic          ready_out, wb_valid_out, wb_we_out, hazard_out;
   logic [4:0]    wb_rgD_index_out;
   logic [W-1:0]  wb_data_out;
   logic [S-1:0]  stage_valid_out;

   int n_checks = 0;
   int n_fail   = 0;

`ifdef MUL_HAZARD_EN
   localparam logic HZ_EXP = 1'b1;
`else
   localparam logic HZ_EXP = 1'b0;
`endif

   always #5 clk = ~clk;

   mul_pipe_ex #(.STAGES(S), .DATA_W(W)) dut (
      .clk              (clk),
      .reset            (reset),
      .valid_in         (valid_in),
      .write_reg_in     (write_reg_in),
      .rgD_index_in     (rgD_index_in),
      .op_a_in          (op_a_in),
      .op_b_in          (op_b_in),
      .flush_in         (flush_in),
      .stall_in         (stall_in),
      .ready_out        (ready_out),
      .wb_valid_out     (wb_valid_out),
      .wb_we_out        (wb_we_out),
      .wb_rgD_index_out (wb_rgD_index_out),
      .wb_data_out      (wb_data_out),
      .stage_valid_out  (stage_valid_out),
      .id_rgS1_index_in (id_rgS1_index_in),
      .id_rgS2_index_in (id_rgS2_index_in),
      .hazard_out       (hazard_out)
   );

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [4:0]   rgd;
      logic         we;
      logic [W-1:0] exp_data;
   } vec_t;

   vec_t vecs [7];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
      end
   endtask

   // Inputs change at the falling edge; outputs are checked at the falling edge after a rising edge.
   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic drive(input logic v, input logic we, input logic [4:0] rgd,
                        input logic [W-1:0] a, input logic [W-1:0] b);
      valid_in     = v;
      write_reg_in = we;
      rgD_index_in = rgd;
      op_a_in      = a;
      op_b_in      = b;
   endtask

   task automatic check_idle_outputs(input string nm);
      chk({nm, "_ready"},  {63'd0, ready_out},    64'd1);
      chk({nm, "_wbv"},    {63'd0, wb_valid_out}, 64'd0);
      chk({nm, "_wbwe"},   {63'd0, wb_we_out},    64'd0);
      chk({nm, "_wbidx"},  {59'd0, wb_rgD_index_out}, 64'd0);
      chk({nm, "_wbdata"}, {32'd0, wb_data_out},  64'd0);
      chk({nm, "_sv"},     {59'd0, stage_valid_out}, 64'd0);
      chk({nm, "_hz"},     {63'd0, hazard_out},   64'd0);
   endtask

   initial begin
      vecs[0] = '{32'd7,          32'd6,          5'd5,  1'b1, 32'd42};
      vecs[1] = '{32'd3,          32'd4,          5'd1,  1'b1, 32'd12};
      vecs[2] = '{32'hFFFF_FFFF,  32'd2,          5'd2,  1'b1, 32'hFFFF_FFFE};
      vecs[3] = '{32'h0001_0000,  32'h0001_0000,  5'd3,  1'b1, 32'h0};
      vecs[4] = '{32'd5,          32'd5,          5'd17, 1'b0, 32'd25};
      vecs[5] = '{32'h1234_5678,  32'h10,         5'd31, 1'b1, 32'h2345_6780};
      vecs[6] = '{32'hFFFF_FFFF,  32'hFFFF_FFFF,  5'd0,  1'b1, 32'h1};

      reset = 1'b0;
      flush_in = 1'b0;
      stall_in = 1'b0;
      id_rgS1_index_in = 5'd0;
      id_rgS2_index_in = 5'd0;
      drive(1'b0, 1'b0, 5'd0, '0, '0);
      #2;
      check_idle_outputs("reset");
      @(negedge clk);
      reset = 1'b1;

      // Back-to-back stream: vector c enters at edge c and retires after edge c+S-1.
      for (int c = 0; c <= 7 + S - 1; c++) begin
         if (c < 7) drive(1'b1, vecs[c].we, vecs[c].rgd, vecs[c].a, vecs[c].b);
         else       drive(1'b0, 1'b0, 5'd0, '0, '0);
         tick();
         if (c >= S - 1 && c - (S - 1) < 7) begin
            chk("stream_wbv",   {63'd0, wb_valid_out}, 64'd1);
            chk("stream_wbwe",  {63'd0, wb_we_out}, {63'd0, vecs[c-(S-1)].we});
            chk("stream_idx",   {59'd0, wb_rgD_index_out}, {59'd0, vecs[c-(S-1)].rgd});
            chk("stream_data",  {32'd0, wb_data_out}, {32'd0, vecs[c-(S-1)].exp_data});
         end else begin
            chk("stream_idle_wbv", {63'd0, wb_valid_out}, 64'd0);
         end
      end

      // Stall at writeback while the next op waits at the input.
      drive(1'b1, 1'b1, 5'd3, 32'd9, 32'd9);
      tick();
      drive(1'b0, 1'b0, 5'd0, '0, '0);
      repeat (S - 1) tick();
      chk("stall_pre_wbv",  {63'd0, wb_valid_out}, 64'd1);
      chk("stall_pre_data", {32'd0, wb_data_out}, 64'd81);
      stall_in = 1'b1;
      drive(1'b1, 1'b1, 5'd4, 32'd2, 32'd3);
      #1;
      chk("stall_ready_comb", {63'd0, ready_out}, 64'd0);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("stall_ready", {63'd0, ready_out}, 64'd0);
         chk("stall_wbv",   {63'd0, wb_valid_out}, 64'd1);
         chk("stall_wbidx", {59'd0, wb_rgD_index_out}, 64'd3);
         chk("stall_data",  {32'd0, wb_data_out}, 64'd81);
         chk("stall_sv",    {59'd0, stage_valid_out}, 64'b10000);
      end
      stall_in = 1'b0;
      #1;
      chk("stall_release_ready", {63'd0, ready_out}, 64'd1);
      tick();
      drive(1'b0, 1'b0, 5'd0, '0, '0);
      chk("stall_drain_wbv", {63'd0, wb_valid_out}, 64'd0);
      chk("stall_drain_sv",  {59'd0, stage_valid_out}, 64'b00001);
      repeat (S - 1) tick();
      chk("held_op_wbv",  {63'd0, wb_valid_out}, 64'd1);
      chk("held_op_idx",  {59'd0, wb_rgD_index_out}, 64'd4);
      chk("held_op_data", {32'd0, wb_data_out}, 64'd6);
      tick();
      chk("held_op_done", {63'd0, wb_valid_out}, 64'd0);

      // Flushed instruction never enters the pipe.
      flush_in = 1'b1;
      drive(1'b1, 1'b1, 5'd8, 32'd3, 32'd3);
      tick();
      flush_in = 1'b0;
      drive(1'b0, 1'b0, 5'd0, '0, '0);
      chk("flush_sv", {59'd0, stage_valid_out}, 64'd0);
      for (int i = 0; i < S; i++) begin
         tick();
         chk("flush_wbv", {63'd0, wb_valid_out}, 64'd0);
      end

      // Stall with an empty last stage lets the op flow until it reaches writeback.
      stall_in = 1'b1;
      drive(1'b1, 1'b1, 5'd7, 32'd4, 32'd5);
      for (int i = 0; i < S; i++) begin
         tick();
         if (i == 0) drive(1'b0, 1'b0, 5'd0, '0, '0);
         chk("bubble_sv",    {59'd0, stage_valid_out}, 64'd1 << i);
         chk("bubble_ready", {63'd0, ready_out}, (i < S - 1) ? 64'd1 : 64'd0);
      end
      chk("bubble_data", {32'd0, wb_data_out}, 64'd20);
      stall_in = 1'b0;
      tick();
      chk("bubble_drained", {59'd0, stage_valid_out}, 64'd0);

      // Asynchronous reset with three ops in flight, the oldest at writeback.
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 1'b1, 5'(10 + i), 32'(i + 2), 32'd10);
         tick();
      end
      drive(1'b0, 1'b0, 5'd0, '0, '0);
      repeat (2) tick();
      chk("rst_pre_sv",   {59'd0, stage_valid_out}, 64'b11100);
      chk("rst_pre_data", {32'd0, wb_data_out}, 64'd20);
      #2;
      reset = 1'b0;
      #1;
      check_idle_outputs("rst_mid");
      @(negedge clk);
      reset = 1'b1;
      for (int i = 0; i < S + 1; i++) begin
         tick();
         chk("rst_after_wbv", {63'd0, wb_valid_out}, 64'd0);
      end

      // Hazard: destination 9 sitting in stage 2.
      drive(1'b1, 1'b1, 5'd9, 32'd1, 32'd1);
      tick();
      drive(1'b0, 1'b0, 5'd0, '0, '0);
      repeat (2) tick();
      chk("hz_sv", {59'd0, stage_valid_out}, 64'b00100);
      id_rgS1_index_in = 5'd1;
      id_rgS2_index_in = 5'd9;
      #1;
      chk("hz_match", {63'd0, hazard_out}, {63'd0, HZ_EXP});
      id_rgS2_index_in = 5'd10;
      #1;
      chk("hz_nomatch", {63'd0, hazard_out}, 64'd0);
      id_rgS2_index_in = 5'd0;
      repeat (S) tick();
      drive(1'b1, 1'b0, 5'd9, 32'd1, 32'd1);
      tick();
      drive(1'b0, 1'b0, 5'd0, '0, '0);
      repeat (2) tick();
      id_rgS2_index_in = 5'd9;
      #1;
      chk("hz_nowe_sv", {59'd0, stage_valid_out}, 64'b00100);
      chk("hz_nowe",    {63'd0, hazard_out}, 64'd0);
      id_rgS2_index_in = 5'd0;
      repeat (S) tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
